// File: rtl/pr_bus_pkg.sv
// Shared processor-bus definitions: widths, register offsets, CTRL layout, mode and FSM encodings.
package pr_bus_pkg;

    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned NUM_REGS = 3;

    // Byte offsets inside the register window and the matching word index
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_PRESET = 8'h04;
    localparam logic [7:0] OFF_COUNT  = 8'h08;
    localparam logic [1:0] IDX_CTRL   = 2'(OFF_CTRL >> 2);
    localparam logic [1:0] IDX_PRESET = 2'(OFF_PRESET >> 2);
    localparam logic [1:0] IDX_COUNT  = 2'(OFF_COUNT >> 2);

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;
    localparam int unsigned CTRL_STAT    = 4;
    localparam int unsigned CTRL_W       = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // Writable CTRL bits, MSB first so it overlays CTRL[3:0]
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/pr_timer_if.sv
// Processor-bus port bundle between the CPU (master) and a bus device (slave).
interface pr_timer_if;
    import pr_bus_pkg::*;

    logic [ADDR_W-1:0] PrAddr;
    logic [BE_W-1:0]   BE;
    logic [DATA_W-1:0] PrWD;
    logic              PrWe;
    logic [DATA_W-1:0] PrRD;
    logic              PrHit;
    logic              IRQ;

    modport master (output PrAddr, BE, PrWD, PrWe, input PrRD, PrHit, IRQ);
    modport slave  (input PrAddr, BE, PrWD, PrWe, output PrRD, PrHit, IRQ);

endinterface

// File: rtl/pr_timer_be_merge.sv
// Byte-enable merge: each byte lane takes write data when its BE bit is set, else keeps the old value.
module be_merge
    import pr_bus_pkg::*;
(
    input  logic [DATA_W-1:0] i_old,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [BE_W-1:0]   i_be,
    output logic [DATA_W-1:0] o_merged_c
);

    always_comb begin
        o_merged_c = i_old;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (i_be[i]) begin
                o_merged_c[8*i +: 8] = i_wd[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/pr_timer.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot and auto-reload interrupt.
// Optional build macro TIMER_STATUS_EN: CTRL[4] mirrors irq_flag for polling.
module pr_timer
    import pr_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic       clk,
    input  logic       rst,
    pr_timer_if.slave  bus
);

    localparam logic [ADDR_W-1:0] BASE_WORD = BASE_ADDR[31:2];

    logic [1:0]        r_state,    w_state_nxt;
    ctrl_t             r_ctrl,     w_ctrl_nxt;
    logic [DATA_W-1:0] r_preset,   w_preset_nxt;
    logic [DATA_W-1:0] r_count,    w_count_nxt;
    logic              r_irq_flag, w_flag_nxt;
    logic              r_irq,      w_irq_nxt;

    logic [ADDR_W-1:0] w_off;
    logic              w_hit;
    logic [1:0]        w_idx;
    logic              w_stat;
    logic [DATA_W-1:0] w_reg_rd;
    logic [DATA_W-1:0] w_merged;
    logic              w_wr_ctrl;
    logic              w_wr_preset;

    // Address decode; addresses below the base wrap to large offsets and miss
    assign w_off = bus.PrAddr - BASE_WORD;
    assign w_hit = (w_off < ADDR_W'(NUM_REGS));
    assign w_idx = w_off[1:0];

`ifdef TIMER_STATUS_EN
    assign w_stat = r_irq_flag;
`else
    assign w_stat = 1'b0;
`endif

    always_comb begin
        w_reg_rd = '0;
        case (w_idx)
            IDX_CTRL: begin
                w_reg_rd[CTRL_W-1:0] = r_ctrl;
                w_reg_rd[CTRL_STAT]  = w_stat;
            end
            IDX_PRESET: w_reg_rd = r_preset;
            IDX_COUNT:  w_reg_rd = r_count;
            default:    w_reg_rd = '0;
        endcase
    end

    assign bus.PrHit = w_hit;
    assign bus.PrRD  = w_hit ? w_reg_rd : '0;
    assign bus.IRQ   = r_irq;

    // Only one register is addressed per access, so one merge serves every write
    be_merge u_be_merge (
        .i_old      (w_reg_rd),
        .i_wd       (bus.PrWD),
        .i_be       (bus.BE),
        .o_merged_c (w_merged)
    );

    assign w_wr_ctrl   = bus.PrWe & w_hit & (w_idx == IDX_CTRL);
    assign w_wr_preset = bus.PrWe & w_hit & (w_idx == IDX_PRESET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_preset   <= w_preset_nxt;
            r_count    <= w_count_nxt;
            r_irq_flag <= w_flag_nxt;
            r_irq      <= w_irq_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ctrl_nxt   = r_ctrl;
        w_preset_nxt = r_preset;
        w_count_nxt  = r_count;
        w_flag_nxt   = r_irq_flag;

        case (r_state)
            ST_IDLE: begin
                if (r_ctrl.en) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                // Clearing here ends the auto-reload pulse after one cycle
                w_count_nxt = r_preset;
                w_flag_nxt  = 1'b0;
                w_state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!r_ctrl.en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count == '0) begin
                    w_state_nxt = ST_INT;
                end else if (r_count == DATA_W'(1)) begin
                    w_count_nxt = '0;
                    w_state_nxt = ST_INT;
                end else begin
                    w_count_nxt = r_count - DATA_W'(1);
                end
            end
            ST_INT: begin
                w_flag_nxt = 1'b1;
                if (r_ctrl.mode == MODE_RELOAD) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_ctrl_nxt.en = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // CPU writes take priority over hardware updates and acknowledge the interrupt
        if (w_wr_ctrl) begin
            w_ctrl_nxt = ctrl_t'(w_merged[CTRL_W-1:0]);
            w_flag_nxt = 1'b0;
        end
        if (w_wr_preset) begin
            w_preset_nxt = w_merged;
            w_flag_nxt   = 1'b0;
        end

        w_irq_nxt = w_flag_nxt & w_ctrl_nxt.im;
    end

endmodule
